uart_tx_framer: RTL

- Serialises parallel bytes into asynchronous UART frames on tx_out.
- Frame format: start bit (0), DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits (1).
- Sits directly upstream of the UART receiver and drives its serial input.
- Bit timing comes from an internal divider, so no external baud clock is needed; the whole block runs on clk.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_tx_framer.sv | 66 ++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity-mode constants and frame-length helper shared by the UART blocks.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD = 1'b1;
    function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: CLKS_PER_BIT divider with synchronous clear; tick is high on the terminal count.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises bytes into start/data/parity/stop UART frames on a registered tx_out.
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 frame_done
);
    import uart_pkg::*;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    uart_state_t state, state_d;
    logic [BW-1:0] bit_cnt, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg;
    logic par, tick, accept, tx_d;
    // Holding the divider clear while idle makes the start bit full length from accept.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
        .clk(clk), .reset(reset), .clr(state == IDLE), .tick(tick)
    );
    assign tx_ready = state == IDLE;
    assign busy = !tx_ready;
    assign accept = tx_valid && tx_ready;
    always_comb begin
        state_d = state;
        case (state)
            IDLE: state_d = accept ? START : IDLE;
            START: state_d = tick ? DATA : START;
            DATA: state_d = (tick && bit_cnt == LAST_DATA) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
            PARITY: state_d = tick ? STOP : PARITY;
            STOP: state_d = (tick && bit_cnt == LAST_STOP) ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
        bit_cnt_d = (state_d != state) ? '0 : bit_cnt + BW'(tick);
        tx_d = (state_d == START) ? 1'b0 :
               (state_d == DATA) ? ((state == DATA && tick) ? shreg[1] : shreg[0]) :
               (state_d == PARITY) ? par : 1'b1;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            bit_cnt <= '0;
            tx_out <= 1'b1;
            frame_done <= 1'b0;
            shreg <= '0;
            par <= 1'b0;
        end else begin
            state <= state_d;
            bit_cnt <= bit_cnt_d;
            tx_out <= tx_d;
            frame_done <= state == STOP && state_d == IDLE;
            if (accept) begin
                shreg <= tx_data;
                par <= (^tx_data) ^ (PARITY_ODD != 0);
            end else if (state == DATA && tick) shreg <= shreg >> 1;
        end
endmodule
